ex_stage_md: RTL and testbench

Next-generation EX stage for the 5-stage RV32 pipeline, parametrised in data width.
- Keeps MEM/WB operand forwarding, the ALU and the ALU_A/ALU_B source selection.
- Adds an iterative multiply/divide unit for the M extension.
- Holds the EX instruction through a stall request until the result is ready.
- Sits between the ID/EX and EX/MEM pipeline registers; hazard control consumes stall_req_ex.

---
 rtl/ex_pkg.sv | 39 +++
 rtl/ex_stage_md_md_unit.sv | 149 ++++++++++++++
 rtl/ex_stage_md.sv | 106 ++++++++++
 tb/tb_ex_stage_md.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU and M-extension operation codes,
// forwarding selects, multiply/divide FSM states and a width helper.
package ex_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring division
// on operand magnitudes. Optional macro EX_MD_EARLY_OUT_EN skips trivial divides.
module md_unit
   import ex_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = clog2(XLEN);
   localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

   md_state_t state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [2:0]        code_reg;
   logic              neg_q_reg, neg_r_reg;
   logic [2*XLEN-1:0] prod_reg, mcand_reg;
   logic [XLEN-1:0]   mplier_reg, quo_reg, rem_reg, dvsr_reg;

   logic              start_ok, is_div, a_sgn, b_sgn, div0, ovf, early, special, last;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] pp [MUL_STEP];
   logic [2*XLEN-1:0] pp_sum, prod_fin;
   logic [XLEN:0]     trial;

   assign start_ok = start && !flush && (state_reg == IDLE);
   assign is_div   = op[2];
   assign a_sgn    = a[XLEN-1] && (op == MD_MUL || op == MD_MULH || op == MD_MULHSU ||
                                   op == MD_DIV || op == MD_REM);
   assign b_sgn    = b[XLEN-1] && (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
   assign a_mag    = a_sgn ? -a : a;
   assign b_mag    = b_sgn ? -b : b;
   assign div0     = is_div && (b == '0);
   assign ovf      = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
`ifdef EX_MD_EARLY_OUT_EN
   assign early    = is_div && (a_mag < b_mag);
`else
   assign early    = 1'b0;
`endif
   assign special  = div0 || ovf || early;
   assign last     = code_reg[2] ? (cnt_reg == DIV_LAST) : (cnt_reg == MUL_LAST);

   generate
      for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
         assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
      end
   endgenerate

   always_comb begin
      pp_sum = '0;
      for (int i = 0; i < MUL_STEP; i++) pp_sum = pp_sum + pp[i];
   end

   assign trial = {rem_reg, quo_reg[XLEN-1]};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_ok) state_next = special ? DONE : BUSY;
         BUSY:    if (last) state_next = DONE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         code_reg   <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         prod_reg   <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         dvsr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start_ok) begin
            code_reg   <= op;
            cnt_reg    <= '0;
            prod_reg   <= '0;
            mcand_reg  <= {{XLEN{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            dvsr_reg   <= b_mag;
            // Special cases store the final quotient/remainder with no sign fix-up.
            neg_q_reg  <= special ? 1'b0 : (a_sgn ^ b_sgn);
            neg_r_reg  <= special ? 1'b0 : a_sgn;
            if (div0) begin
               quo_reg <= '1;
               rem_reg <= a;
            end else if (ovf) begin
               quo_reg <= {1'b1, {(XLEN-1){1'b0}}};
               rem_reg <= '0;
            end else if (early) begin
               quo_reg <= '0;
               rem_reg <= a;
            end else begin
               quo_reg <= a_mag;
               rem_reg <= '0;
            end
         end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (code_reg[2]) begin
               if (trial >= {1'b0, dvsr_reg}) begin
                  rem_reg <= XLEN'(trial - {1'b0, dvsr_reg});
                  quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
               end else begin
                  rem_reg <= trial[XLEN-1:0];
                  quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
               end
            end else begin
               prod_reg   <= prod_reg + pp_sum;
               mcand_reg  <= mcand_reg << MUL_STEP;
               mplier_reg <= mplier_reg >> MUL_STEP;
            end
         end
      end
   end

   assign prod_fin = neg_q_reg ? -prod_reg : prod_reg;

   always_comb begin
      result = '0;
      case (code_reg)
         MD_MUL:                   result = prod_fin[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fin[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:          result = neg_q_reg ? -quo_reg : quo_reg;
         default:                  result = neg_r_reg ? -rem_reg : rem_reg;
      endcase
   end

   assign busy = start_ok || (state_reg == BUSY);
   assign done = (state_reg == DONE);

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: operand forwarding, ALU source selection, ALU and an iterative
// M-extension unit that stalls the pipeline until its result is ready.
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_ex,
   input  logic            flush_ex,
   input  logic [3:0]      ALUCode_ex,
   input  logic            MDOp_ex,
   input  logic [2:0]      MDCode_ex,
   input  logic            ALUSrcA_ex,
   input  logic [1:0]      ALUSrcB_ex,
   input  logic [XLEN-1:0] Imm_ex,
   input  logic [XLEN-1:0] PC_ex,
   input  logic [XLEN-1:0] rs1Data_ex,
   input  logic [XLEN-1:0] rs2Data_ex,
   input  logic [4:0]      rs1Addr_ex,
   input  logic [4:0]      rs2Addr_ex,
   input  logic [4:0]      rdAddr_mem,
   input  logic [4:0]      rdAddr_wb,
   input  logic            RegWrite_mem,
   input  logic            RegWrite_wb,
   input  logic [XLEN-1:0] ALUResult_mem,
   input  logic [XLEN-1:0] RegWriteData_wb,
   output logic            stall_req_ex,
   output logic [XLEN-1:0] ALUResult_ex,
   output logic [XLEN-1:0] MemWriteData_ex,
   output logic [XLEN-1:0] ALU_A,
   output logic [XLEN-1:0] ALU_B
);
   localparam int SHW = clog2(XLEN);

   logic [1:0]      fwd_sel_a, fwd_sel_b;
   logic [XLEN-1:0] fwd_a, fwd_b, alu_out, md_result;
   logic [SHW-1:0]  shamt;
   logic            md_done;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                          input logic [4:0] rdm, input logic ww,
                                          input logic [4:0] rdw);
      if (wm && rdm != 5'd0 && rdm == rs) return FWD_MEM;
      if (ww && rdw != 5'd0 && rdw == rs) return FWD_WB;
      return FWD_RF;
   endfunction

   assign fwd_sel_a = fwd_sel(rs1Addr_ex, RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb);
   assign fwd_sel_b = fwd_sel(rs2Addr_ex, RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb);

   assign fwd_a = (fwd_sel_a == FWD_MEM) ? ALUResult_mem :
                  (fwd_sel_a == FWD_WB)  ? RegWriteData_wb : rs1Data_ex;
   assign fwd_b = (fwd_sel_b == FWD_MEM) ? ALUResult_mem :
                  (fwd_sel_b == FWD_WB)  ? RegWriteData_wb : rs2Data_ex;

   assign MemWriteData_ex = fwd_b;
   assign ALU_A = ALUSrcA_ex ? PC_ex : fwd_a;

   always_comb begin
      case (ALUSrcB_ex)
         2'd1:    ALU_B = Imm_ex;
         2'd2:    ALU_B = XLEN'(4);
         default: ALU_B = fwd_b;
      endcase
   end

   assign shamt = ALU_B[SHW-1:0];

   always_comb begin
      alu_out = '0;
      case (ALUCode_ex)
         ALU_ADD:  alu_out = ALU_A + ALU_B;
         ALU_SUB:  alu_out = ALU_A - ALU_B;
         ALU_SLL:  alu_out = ALU_A << shamt;
         ALU_SLT:  alu_out = XLEN'($signed(ALU_A) < $signed(ALU_B));
         ALU_SLTU: alu_out = XLEN'(ALU_A < ALU_B);
         ALU_XOR:  alu_out = ALU_A ^ ALU_B;
         ALU_SRL:  alu_out = ALU_A >> shamt;
         ALU_SRA:  alu_out = $unsigned($signed(ALU_A) >>> shamt);
         ALU_OR:   alu_out = ALU_A | ALU_B;
         ALU_AND:  alu_out = ALU_A & ALU_B;
         ALU_LUI:  alu_out = ALU_B;
         default:  alu_out = '0;
      endcase
   end

   md_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) u_md (
      .clk    (clk),
      .reset  (reset),
      .start  (valid_ex && MDOp_ex && !flush_ex),
      .flush  (flush_ex),
      .op     (MDCode_ex),
      .a      (fwd_a),
      .b      (fwd_b),
      .busy   (stall_req_ex),
      .done   (md_done),
      .result (md_result)
   );

   // Outside DONE the M-unit value is meaningless but the stall keeps it from being consumed.
   assign ALUResult_ex = (MDOp_ex && md_done) ? md_result : (MDOp_ex ? '0 : alu_out);

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed self-checking bench for ex_stage_md (XLEN 32, MUL_STEP 1);
// honours EX_MD_EARLY_OUT_EN for the early-out latency expectation.
module tb_ex_stage_md;
   logic        clk = 1'b0;
   logic        reset, valid_ex, flush_ex, MDOp_ex, ALUSrcA_ex;
   logic [3:0]  ALUCode_ex;
   logic [2:0]  MDCode_ex;
   logic [1:0]  ALUSrcB_ex;
   logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
   logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
   logic        RegWrite_mem, RegWrite_wb;
   logic        stall_req_ex;
   logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_stage_md #(.XLEN(32), .MUL_STEP(1)) dut (
      .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush_ex(flush_ex),
      .ALUCode_ex(ALUCode_ex), .MDOp_ex(MDOp_ex), .MDCode_ex(MDCode_ex),
      .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex), .PC_ex(PC_ex),
      .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex), .rs1Addr_ex(rs1Addr_ex),
      .rs2Addr_ex(rs2Addr_ex), .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb),
      .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb), .ALUResult_mem(ALUResult_mem),
      .RegWriteData_wb(RegWriteData_wb), .stall_req_ex(stall_req_ex),
      .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
      .ALU_A(ALU_A), .ALU_B(ALU_B)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one M-extension op and counts stall cycles until DONE.
   task automatic run_md(input string tag, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_stall, input bit fwd_mem);
      int n;
      valid_ex = 1'b1; MDOp_ex = 1'b1; MDCode_ex = code; flush_ex = 1'b0;
      ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0; RegWrite_wb = 1'b0;
      rs2Addr_ex = 5'd2; rs2Data_ex = b;
      if (fwd_mem) begin
         rs1Addr_ex = 5'd5; rdAddr_mem = 5'd5; RegWrite_mem = 1'b1;
         ALUResult_mem = a; rs1Data_ex = 32'hDEADBEEF;
      end else begin
         rs1Addr_ex = 5'd1; RegWrite_mem = 1'b0; rs1Data_ex = a;
      end
      #1;
      n = 0;
      while (stall_req_ex && n < 200) begin
         n++;
         step();
         if (fwd_mem && n == 1) begin
            ALUResult_mem = 32'h64;
            #1;
         end
      end
      chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
      chk({tag, "_res"}, ALUResult_ex, exp_res);
      $display("md %s a=%h b=%h result=%h stall_cycles=%0d", tag, a, b, ALUResult_ex, n);
      step();
      RegWrite_mem = 1'b0;
   endtask

   task automatic set_add(input logic [31:0] x, input logic [31:0] y);
      valid_ex = 1'b1; MDOp_ex = 1'b0; ALUCode_ex = 4'd0; flush_ex = 1'b0;
      ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = x; rs2Data_ex = y;
   endtask

   initial begin
      reset = 1'b1; valid_ex = 1'b0; flush_ex = 1'b0; MDOp_ex = 1'b0; ALUSrcA_ex = 1'b0;
      ALUCode_ex = 4'd0; MDCode_ex = 3'd0; ALUSrcB_ex = 2'd0; Imm_ex = 32'h0;
      PC_ex = 32'h1000; rs1Data_ex = 32'h0; rs2Data_ex = 32'h0; ALUResult_mem = 32'h0;
      RegWriteData_wb = 32'h0; rs1Addr_ex = 5'd0; rs2Addr_ex = 5'd0; rdAddr_mem = 5'd0;
      rdAddr_wb = 5'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
      step(); step();
      chk("reset_stall", 32'(stall_req_ex), 32'd0);
      reset = 1'b0;
      step();
      MDOp_ex = 1'b1; valid_ex = 1'b0; #1;
      chk("invalid_md_no_stall", 32'(stall_req_ex), 32'd0);

      // Forwarding priority and x0 exclusion
      set_add(32'h33, 32'h5);
      rs1Addr_ex = 5'd5; RegWrite_mem = 1'b1; rdAddr_mem = 5'd5; ALUResult_mem = 32'h11;
      RegWrite_wb = 1'b1; rdAddr_wb = 5'd5; RegWriteData_wb = 32'h22; #1;
      chk("fwd_mem_a", ALU_A, 32'h11);
      chk("fwd_add", ALUResult_ex, 32'h16);
      chk("fwd_nostall", 32'(stall_req_ex), 32'd0);
      $display("alu fwd_mem A=%h B=%h result=%h", ALU_A, ALU_B, ALUResult_ex);
      RegWrite_mem = 1'b0; #1;
      chk("fwd_wb_a", ALU_A, 32'h22);
      rs1Addr_ex = 5'd0; rdAddr_mem = 5'd0; RegWrite_mem = 1'b1; rdAddr_wb = 5'd0; #1;
      chk("fwd_x0_a", ALU_A, 32'h33);
      rs2Addr_ex = 5'd7; rdAddr_wb = 5'd7; #1;
      chk("fwd_wb_store", MemWriteData_ex, 32'h22);
      ALUSrcA_ex = 1'b1; ALUSrcB_ex = 2'd2; #1;
      chk("pc_plus4", ALUResult_ex, 32'h1004);
      ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd1; Imm_ex = 32'h40; ALUCode_ex = 4'd1; #1;
      chk("sub_imm", ALUResult_ex, 32'hFFFFFFF3);
      $display("alu sub_imm A=%h B=%h result=%h", ALU_A, ALU_B, ALUResult_ex);
      step();

      // Multiply / divide paths
      run_md("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
      run_md("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
      run_md("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33, 1'b0);
      run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
      run_md("div_by0", 3'd4, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
      run_md("rem_by0", 3'd6, 32'd100, 32'd0, 32'd100, 1, 1'b0);
      run_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
      run_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1'b0);
      run_md("div_fwd", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b1);
      run_md("rem_fwd", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b1);
      run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
`ifdef EX_MD_EARLY_OUT_EN
      run_md("divu_small", 3'd5, 32'd3, 32'd10, 32'd0, 1, 1'b0);
      run_md("remu_small", 3'd7, 32'd3, 32'd10, 32'd3, 1, 1'b0);
`else
      run_md("divu_small", 3'd5, 32'd3, 32'd10, 32'd0, 33, 1'b0);
      run_md("remu_small", 3'd7, 32'd3, 32'd10, 32'd3, 33, 1'b0);
`endif

      // Flush during BUSY cycle 5
      valid_ex = 1'b1; MDOp_ex = 1'b1; MDCode_ex = 3'd0; rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;
      rs1Data_ex = 32'd7; rs2Data_ex = 32'd3; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
      ALUSrcB_ex = 2'd0; #1;
      chk("flush_issue_stall", 32'(stall_req_ex), 32'd1);
      repeat (5) step();
      flush_ex = 1'b1;
      step();
      set_add(32'd3, 32'd4); #1;
      chk("flush_stall_low", 32'(stall_req_ex), 32'd0);
      chk("flush_add", ALUResult_ex, 32'd7);
      $display("flush add result=%h stall=%0d", ALUResult_ex, stall_req_ex);
      step();
      run_md("mul_after_flush", 3'd0, 32'd7, 32'd3, 32'd21, 33, 1'b0);

      // Reset during BUSY cycle 5
      valid_ex = 1'b1; MDOp_ex = 1'b1; MDCode_ex = 3'd4; rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;
      rs1Data_ex = 32'd50; rs2Data_ex = 32'd5; ALUSrcB_ex = 2'd0; #1;
      chk("reset_issue_stall", 32'(stall_req_ex), 32'd1);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_add(32'd10, 32'd5); #1;
      chk("reset_stall_low", 32'(stall_req_ex), 32'd0);
      chk("reset_add", ALUResult_ex, 32'd15);
      $display("reset add result=%h stall=%0d", ALUResult_ex, stall_req_ex);
      step();
      run_md("div_after_reset", 3'd4, 32'd50, 32'd5, 32'd10, 33, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
